fp32_accumulator: RTL and testbench

- Downstream consumer of the two-operand CORDIC/add stage. Takes each single-precision result it produces and keeps a running IEEE-754 sum over a programmed number of samples.
- Reports the final sum with a one-cycle done pulse.
- Sits between the CORDIC top and the custom-instruction result mux; internally sequential: one multi-cycle FP add per sample.

---
 rtl/fp32_pkg.sv | 36 +++
 rtl/fp32_add_core.sv | 174 +++++++++++++++++
 rtl/fp32_accumulator.sv | 140 ++++++++++++++
 tb/tb_fp32_accumulator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared constants, field layout and FSM state type for the FP32 accumulator.
// Optional flags output is enabled by defining FP32_ACC_FLAGS_EN.
package fp32_pkg;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam int unsigned EXP_BIAS  = 127;
    localparam int unsigned EXP_MAX   = 2 * EXP_BIAS + 1;

    localparam int unsigned SIGN_W = 1;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        ADDING  = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // Leading-zero count of a 27-bit working significand (MSB at bit 26).
    function automatic logic [4:0] lzc27(input logic [26:0] x);
        lzc27 = 5'd0;
        for (int i = 0; i <= 26; i++) begin
            if (x[i]) lzc27 = 5'(26 - i);
        end
    endfunction

endpackage

// File: rtl/fp32_add_core.sv
// Fixed-latency IEEE-754 single adder: RNE, denormals-as-zero, flush-to-zero.
// Operands are registered on in_valid; result appears ADD_LAT cycles later.
module fp32_add_core
    import fp32_pkg::*;
#(
    parameter int unsigned ADD_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] sum,
    output logic [2:0]  flags
);

    localparam int unsigned DEPTH = ADD_LAT - 1;

    fp32_t       r_a, r_b;
    logic        r_v;
    logic [31:0] r_ps [DEPTH];
    logic [2:0]  r_pf [DEPTH];
    logic        r_pv [DEPTH];

    logic [31:0]       w_sum;
    logic [2:0]        w_flags;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic              w_swap, w_s_big, w_exact_zero, w_rnd;
    logic [EXP_W-1:0]  w_e_big, w_e_sml, w_d;
    logic [26:0]       w_big_x, w_sml_x, w_aligned, w_lost, w_mant;
    logic [27:0]       w_sum28;
    logic [4:0]        w_lz;
    logic [24:0]       w_m25;
    logic [FRAC_W-1:0] w_frac;
    logic signed [9:0] w_exp;

    assign w_a_nan  = (r_a.exp == 8'hFF) && (r_a.frac != '0);
    assign w_b_nan  = (r_b.exp == 8'hFF) && (r_b.frac != '0);
    assign w_a_inf  = (r_a.exp == 8'hFF) && (r_a.frac == '0);
    assign w_b_inf  = (r_b.exp == 8'hFF) && (r_b.frac == '0);
    assign w_a_zero = (r_a.exp == 8'h00);
    assign w_b_zero = (r_b.exp == 8'h00);

    // Combinational add on the registered operands; flags = {nan, overflow, underflow}.
    always_comb begin
        w_sum        = FP32_ZERO;
        w_flags      = 3'b000;
        w_swap       = 1'b0;
        w_s_big      = 1'b0;
        w_exact_zero = 1'b0;
        w_rnd        = 1'b0;
        w_e_big      = '0;
        w_e_sml      = '0;
        w_d          = '0;
        w_big_x      = '0;
        w_sml_x      = '0;
        w_aligned    = '0;
        w_lost       = '0;
        w_mant       = '0;
        w_sum28      = '0;
        w_lz         = '0;
        w_m25        = '0;
        w_frac       = '0;
        w_exp        = '0;
        if (w_a_nan || w_b_nan) begin
            w_sum      = FP32_QNAN;
            w_flags[2] = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            if (r_a.sign != r_b.sign) begin
                w_sum      = FP32_QNAN;
                w_flags[2] = 1'b1;
            end else begin
                w_sum = r_a;
            end
        end else if (w_a_inf) begin
            w_sum = r_a;
        end else if (w_b_inf) begin
            w_sum = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_sum = {r_a.sign & r_b.sign, 31'd0};
        end else if (w_a_zero) begin
            w_sum = r_b;
        end else if (w_b_zero) begin
            w_sum = r_a;
        end else begin
            w_swap  = {r_b.exp, r_b.frac} > {r_a.exp, r_a.frac};
            w_s_big = w_swap ? r_b.sign[0] : r_a.sign[0];
            w_e_big = w_swap ? r_b.exp : r_a.exp;
            w_e_sml = w_swap ? r_a.exp : r_b.exp;
            w_big_x = w_swap ? {1'b1, r_b.frac, 3'b000} : {1'b1, r_a.frac, 3'b000};
            w_sml_x = w_swap ? {1'b1, r_a.frac, 3'b000} : {1'b1, r_b.frac, 3'b000};
            w_d     = w_e_big - w_e_sml;
            w_exp   = $signed({2'b00, w_e_big});
            if (w_d > 8'd26) begin
                w_aligned = 27'd1;
            end else begin
                w_aligned    = w_sml_x >> w_d;
                w_lost       = w_sml_x & ((27'd1 << w_d) - 27'd1);
                w_aligned[0] = w_aligned[0] | (|w_lost);
            end
            if (r_a.sign == r_b.sign) begin
                w_sum28 = {1'b0, w_big_x} + {1'b0, w_aligned};
                if (w_sum28[27]) begin
                    w_mant = {w_sum28[27:2], w_sum28[1] | w_sum28[0]};
                    w_exp  = w_exp + 10'sd1;
                end else begin
                    w_mant = w_sum28[26:0];
                end
            end else begin
                w_mant = w_big_x - w_aligned;
                if (w_mant == '0) begin
                    w_exact_zero = 1'b1;
                end else begin
                    w_lz   = lzc27(w_mant);
                    w_mant = w_mant << w_lz;
                    w_exp  = w_exp - $signed({5'd0, w_lz});
                end
            end
            w_rnd = w_mant[2] & (w_mant[1] | w_mant[0] | w_mant[3]);
            w_m25 = {1'b0, w_mant[26:3]} + 25'(w_rnd);
            if (w_m25[24]) begin
                w_frac = w_m25[23:1];
                w_exp  = w_exp + 10'sd1;
            end else begin
                w_frac = w_m25[22:0];
            end
            if (w_exact_zero) begin
                w_sum = FP32_ZERO;
            end else if (w_exp <= 10'sd0) begin
                w_sum      = FP32_ZERO;
                w_flags[0] = 1'b1;
            end else if (w_exp >= $signed(10'(EXP_MAX))) begin
                w_sum      = {w_s_big, FP32_PINF[30:0]};
                w_flags[1] = 1'b1;
            end else begin
                w_sum = {w_s_big, w_exp[7:0], w_frac};
            end
        end
    end

    // Operand capture followed by ADD_LAT-1 result delay stages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= 1'b0;
            r_a <= '0;
            r_b <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ps[i] <= '0;
                r_pf[i] <= '0;
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_v <= in_valid;
            if (in_valid) begin
                r_a <= fp32_t'(a);
                r_b <= fp32_t'(b);
            end
            r_pv[0] <= r_v;
            r_ps[0] <= w_sum;
            r_pf[0] <= w_flags;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
                r_pf[i] <= r_pf[i-1];
            end
        end
    end

    assign out_valid = r_pv[DEPTH-1];
    assign sum       = r_ps[DEPTH-1];
    assign flags     = r_pf[DEPTH-1];

endmodule

// File: rtl/fp32_accumulator.sv
// Running FP32 sum over a programmed number of samples, one add in flight at a time.
// Define FP32_ACC_FLAGS_EN to add the sticky {nan, overflow, underflow} flags output.
module fp32_accumulator
    import fp32_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned ADD_LAT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
`ifdef FP32_ACC_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int unsigned LAT_W = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_remaining;
    logic [31:0]      r_sum;
    logic [LAT_W-1:0] r_lat_cnt;
    logic             r_in_ready, r_busy, r_done;
    logic [31:0]      r_result;

    logic             w_hs, w_accept;
    logic             w_core_valid;
    logic [31:0]      w_core_sum;
    logic [2:0]       w_core_flags;

    fp32_add_core #(.ADD_LAT(ADD_LAT)) u_add (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (w_hs),
        .a         (r_sum),
        .b         (in_data),
        .out_valid (w_core_valid),
        .sum       (w_core_sum),
        .flags     (w_core_flags)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Only the result launched by this run's handshake is accepted; aborted adds arrive off-count.
    always_comb begin
        w_next_state = r_state;
        w_hs         = 1'b0;
        w_accept     = (r_state == ADDING) && w_core_valid && !start &&
                       (r_lat_cnt == LAT_W'(ADD_LAT - 1));
        if (start) begin
            w_next_state = (count == '0) ? FINISH : WAIT_IN;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                WAIT_IN: begin
                    if (in_valid && r_in_ready) begin
                        w_hs         = 1'b1;
                        w_next_state = ADDING;
                    end
                end
                ADDING: begin
                    if (w_accept)
                        w_next_state = (r_remaining == CNT_W'(1)) ? FINISH : WAIT_IN;
                end
                FINISH:  w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_sum       <= FP32_ZERO;
            r_lat_cnt   <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= FP32_ZERO;
        end else begin
            r_in_ready <= (w_next_state == WAIT_IN);
            r_busy     <= (w_next_state != IDLE);
            r_done     <= (r_state == FINISH) && !start;
            if (start) begin
                r_remaining <= count;
                r_sum       <= FP32_ZERO;
            end else if (w_accept) begin
                r_remaining <= r_remaining - CNT_W'(1);
                r_sum       <= w_core_sum;
            end
            if (w_hs)
                r_lat_cnt <= '0;
            else if (r_state == ADDING)
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            if ((r_state == FINISH) && !start)
                r_result <= r_sum;
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

`ifdef FP32_ACC_FLAGS_EN
    logic [2:0] r_run_flags, r_flags;

    // Sticky per run, published together with the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_flags <= '0;
            r_flags     <= '0;
        end else begin
            if (start)
                r_run_flags <= '0;
            else if (w_accept)
                r_run_flags <= r_run_flags | w_core_flags;
            if ((r_state == FINISH) && !start)
                r_flags <= r_run_flags;
        end
    end

    assign flags = r_flags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^w_core_flags;
`endif

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed self-checking bench for fp32_accumulator (hand-computed IEEE-754 sums).
module tb_fp32_accumulator;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ADD_LAT = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic [31:0]      result;
`ifdef FP32_ACC_FLAGS_EN
    logic [2:0]       flags;
`endif

    fp32_accumulator #(.CNT_W(CNT_W), .ADD_LAT(ADD_LAT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef FP32_ACC_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int n_hs = 0;
    int n_done = 0;
    int last_hs = 0;
    int last_start = 0;
    int done_cyc = 0;
    logic [31:0] smp [8];

    // Edge-numbered record of handshakes, start pulses and done pulses.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (in_valid && in_ready && !start) begin
            n_hs    <= n_hs + 1;
            last_hs <= cyc_cnt + 1;
        end
        if (start) last_start <= cyc_cnt + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc_cnt;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input int n);
        start = 1'b1;
        count = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input int n, input bit hold);
        int hs0;
        int g;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = smp[i];
            hs0 = n_hs;
            g   = 0;
            while (n_hs == hs0 && g < 50) begin
                @(negedge clk);
                g++;
            end
            chk({tag, "_hs"}, 32'(n_hs - hs0), 32'd1);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dn0);
        int g;
        g = 0;
        while (n_done == dn0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_done"}, 32'(n_done - dn0), 32'd1);
    endtask

    task automatic run(input string tag, input int n, input logic [31:0] exp);
        int dn0;
        dn0 = n_done;
        pulse_start(n);
        feed(tag, n, 1'b0);
        wait_done(tag, dn0);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_lat"}, 32'(done_cyc - last_hs), 32'(ADD_LAT + 1));
    endtask

    initial begin
        int dn0;
        int hs0;
        reset_n  = 1'b1;
        start    = 1'b0;
        count    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1 + 2 + 0.5 = 3.5
        smp[0] = 32'h3F80_0000; smp[1] = 32'h4000_0000; smp[2] = 32'h3F00_0000;
        dn0 = n_done;
        pulse_start(3);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        feed("t1", 3, 1'b0);
        wait_done("t1", dn0);
        chk("t1_res", result, 32'h4060_0000);
        chk("t1_lat", 32'(done_cyc - last_hs), 32'(ADD_LAT + 1));
`ifdef FP32_ACC_FLAGS_EN
        chk("t1_flags", 32'(flags), 32'd0);
`endif
        repeat (4) @(negedge clk);
        chk("t1_single_done", 32'(n_done - dn0), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_hold", result, 32'h4060_0000);

        // 1 + -1 cancels exactly to +0; result holds across the new start
        smp[0] = 32'h3F80_0000; smp[1] = 32'hBF80_0000;
        dn0 = n_done;
        pulse_start(2);
        chk("t2a_hold_at_start", result, 32'h4060_0000);
        feed("t2a", 2, 1'b0);
        wait_done("t2a", dn0);
        chk("t2a_res", result, 32'h0000_0000);

        // 1 + 2^-24 is an exact tie, rounds to even (1.0)
        smp[0] = 32'h3F80_0000; smp[1] = 32'h3380_0000;
        run("t2b", 2, 32'h3F80_0000);

        // Two max-finite values overflow to +Inf
        smp[0] = 32'h7F7F_FFFF; smp[1] = 32'h7F7F_FFFF;
        run("t3", 2, 32'h7F80_0000);
`ifdef FP32_ACC_FLAGS_EN
        chk("t3_flags", 32'(flags), 32'd2);
`endif

        // NaN in the middle propagates; in_valid held high is consumed once per handshake
        smp[0] = 32'h3F80_0000; smp[1] = 32'h7FC0_0000; smp[2] = 32'h4000_0000;
        dn0 = n_done;
        hs0 = n_hs;
        pulse_start(3);
        feed("t4", 3, 1'b1);
        wait_done("t4", dn0);
        repeat (3) @(negedge clk);
        chk("t4_hs_total", 32'(n_hs - hs0), 32'd3);
        in_valid = 1'b0;
        chk("t4_res", result, 32'h7FC0_0000);
`ifdef FP32_ACC_FLAGS_EN
        chk("t4_flags", 32'(flags), 32'd4);
`endif

        // count == 0: done one cycle after start, result +0
        dn0 = n_done;
        pulse_start(0);
        wait_done("t5", dn0);
        chk("t5_res", result, 32'h0000_0000);
        chk("t5_lat", 32'(done_cyc - last_start), 32'd1);

        // Abort a count=4 run mid-ADDING, then 1 + 1 = 2
        smp[0] = 32'h4000_0000;
        dn0 = n_done;
        pulse_start(4);
        feed("t6a", 1, 1'b0);
        pulse_start(2);
        smp[0] = 32'h3F80_0000; smp[1] = 32'h3F80_0000;
        feed("t6b", 2, 1'b0);
        wait_done("t6", dn0);
        chk("t6_res", result, 32'h4000_0000);
        repeat (4) @(negedge clk);
        chk("t6_single_done", 32'(n_done - dn0), 32'd1);

        // Asynchronous reset mid-run clears outputs without a clock edge
        smp[0] = 32'h3F80_0000;
        pulse_start(3);
        feed("t7a", 1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_result", result, 32'h0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_ready", 32'(in_ready), 32'd0);
        chk("t7_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        smp[0] = 32'h4040_0000;
        run("t7", 1, 32'h4040_0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
